rr_mux_arbiter: RTL and testbench

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for eight requesters driving an 8:1 mux select.
// Define ARB_HOLD_LIMIT_EN to cap continuous ownership at MAX_HOLD cycles when others wait.
module rr_mux_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy,
    output logic       dbg_state
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [7:0] gnt_nxt;
    logic [2:0] sel_nxt;
    logic       busy_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] winner;
    logic       take;
    logic       limit_hit;

    // First requester found scanning last+1 .. last+8, wrapping; the last one is lowest priority.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
        logic [2:0] idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = last + 3'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign winner    = rr_pick(req, ptr);
    assign dbg_state = (state == GRANT);

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic       others;

    assign others    = |(req & ~(8'b1 << sel));
    assign limit_hit = (hold_cnt == HOLD_LAST) && others;

    // Counter saturates so a lone owner keeps its grant without wrapping.
    always_comb begin
        hold_cnt_nxt = hold_cnt;
        if (take)
            hold_cnt_nxt = 8'd0;
        else if (state == GRANT && req != 8'h00 && hold_cnt != HOLD_LAST)
            hold_cnt_nxt = hold_cnt + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            hold_cnt <= 8'd0;
        else
            hold_cnt <= hold_cnt_nxt;
    end
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        busy_nxt  = busy;
        ptr_nxt   = ptr;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (req != 8'h00)
                    take = 1'b1;
            end
            GRANT: begin
                if (req == 8'h00) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 8'h00;
                    busy_nxt  = 1'b0;
                end else if (!req[sel] || limit_hit) begin
                    take = 1'b1;
                end
            end
            default: ;
        endcase
        // A handoff goes straight to the next owner, no idle bubble.
        if (take) begin
            state_nxt = GRANT;
            gnt_nxt   = 8'b1 << winner;
            sel_nxt   = winner;
            busy_nxt  = 1'b1;
            ptr_nxt   = winner;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= 8'h00;
            sel   <= 3'd0;
            busy  <= 1'b0;
            ptr   <= 3'd7;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
            busy  <= busy_nxt;
            ptr   <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed and random checks for rr_mux_arbiter; expectations queued by the driver, checked by a monitor.
module tb_rr_mux_arbiter;

    logic       clock;
    logic       reset;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       dbg_state;

`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [11:0] exp_q[$];
    string       name_q[$];

    rr_mux_arbiter #(.MAX_HOLD(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock/reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // driver: apply one cycle of inputs and queue the outputs expected after the next edge
    task automatic step(input logic r_rst, input logic [7:0] r_req,
                        input logic [7:0] eg, input logic [2:0] es, input logic eb,
                        input string nm);
        @(negedge clock);
        reset = r_rst;
        req   = r_req;
        exp_q.push_back({eg, es, eb});
        name_q.push_back(nm);
    endtask

    task automatic drive_only(input logic [7:0] r_req);
        @(negedge clock);
        reset = 1'b0;
        req   = r_req;
    endtask

    // monitor / scoreboard
    logic [7:0] req_edge;
    logic       rst_edge;
    logic [7:0] prev_gnt = 8'h00;
    int         wait_cnt[8];

    always @(posedge clock) begin
        logic [11:0] e;
        string       nm;
        req_edge = req;
        rst_edge = reset;
        #1;
        vectors++;
        if ($countones(gnt) > 1) begin
            miscompares++;
            $display("FAIL onehot: gnt=%h has more than one bit set", gnt);
        end
        vectors++;
        if (gnt[sel] !== busy) begin
            miscompares++;
            $display("FAIL gnt_sel_busy: gnt[sel]=%b busy=%b (sel=%0d) must be equal", gnt[sel], busy, sel);
        end
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            vectors++;
            if ({gnt, sel, busy} !== e) begin
                miscompares++;
                $display("FAIL %s: got gnt=%h sel=%0d busy=%b, expected gnt=%h sel=%0d busy=%b",
                         nm, gnt, sel, busy, e[11:4], e[3:1], e[0]);
            end
        end
        if (rst_edge) begin
            for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
        end else begin
            for (int i = 0; i < 8; i++) if (!req_edge[i]) wait_cnt[i] = 0;
            if (gnt != 8'h00 && gnt != prev_gnt) begin
                int worst = 0;
                for (int i = 0; i < 8; i++) begin
                    if (gnt[i]) wait_cnt[i] = 0;
                    else if (req_edge[i]) wait_cnt[i]++;
                    if (wait_cnt[i] > worst) worst = wait_cnt[i];
                end
                vectors++;
                if (worst > 7) begin
                    miscompares++;
                    $display("FAIL starvation: a requester waited %0d grants, limit 7", worst);
                end
            end
        end
        prev_gnt = gnt;
    end

    initial begin
        int owner;
        reset = 1'b1;
        req   = 8'h00;

        // reset values and single requester
        step(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "reset_a");
        step(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "reset_b");
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, "idle_after_reset");
        step(1'b0, 8'h01, 8'h01, 3'd0, 1'b1, "first_grant_r0");
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, "drop_to_idle");

        // all requesting, each owner releases after two cycles: 0..7,0 with no bubble
        step(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "reset_before_rotate");
        step(1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, "rotate_start");
        for (int k = 0; k < 8; k++) begin
            owner = (k + 1) % 8;
            step(1'b0, 8'hFF, 8'b1 << k, 3'(k), 1'b1, "rotate_hold");
            step(1'b0, ~(8'b1 << k), 8'b1 << owner, 3'(owner), 1'b1, "rotate_handoff");
        end
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, "rotate_idle");

        // owner 3 then handoff to 5, then idle keeping sel
        step(1'b0, 8'h08, 8'h08, 3'd3, 1'b1, "grant_r3");
        step(1'b0, 8'h28, 8'h08, 3'd3, 1'b1, "r3_hold_with_r5");
        step(1'b0, 8'h20, 8'h20, 3'd5, 1'b1, "handoff_r5");
        step(1'b0, 8'h00, 8'h00, 3'd5, 1'b0, "idle_sel_held_5");

        // non-owner churn leaves owner 2 alone
        step(1'b0, 8'h04, 8'h04, 3'd2, 1'b1, "grant_r2");
        step(1'b0, 8'h0C, 8'h04, 3'd2, 1'b1, "churn_add_r3");
        step(1'b0, 8'h05, 8'h04, 3'd2, 1'b1, "churn_swap_r0");
        step(1'b0, 8'h04, 8'h04, 3'd2, 1'b1, "churn_drop_all");
        step(1'b0, 8'h00, 8'h00, 3'd2, 1'b0, "idle_sel_held_2");

        // two requesters held: alternating every 4 cycles with hold limit, else owner 0 forever
        for (int c = 0; c < 16; c++) begin
            owner = HOLD_EN ? (c / 4) % 2 : 0;
            step(1'b0, 8'h03, 8'b1 << owner, 3'(owner), 1'b1, "hold_pair");
        end
        step(1'b0, 8'h01, 8'h01, 3'd0, 1'b1, "lone_r0_take");
        for (int c = 0; c < 8; c++)
            step(1'b0, 8'h01, 8'h01, 3'd0, 1'b1, "lone_r0_keep");
        owner = HOLD_EN ? 1 : 0;
        step(1'b0, 8'h03, 8'b1 << owner, 3'(owner), 1'b1, "saturated_then_compete");
        step(1'b0, 8'h00, 8'h00, 3'(owner), 1'b0, "idle_after_pair");

        // reset pulse during a grant to owner 6
        step(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "reset_before_r6");
        step(1'b0, 8'h40, 8'h40, 3'd6, 1'b1, "grant_r6");
        step(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, "reset_drops_grant");
        step(1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, "r0_first_after_reset");
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, "idle_end_directed");

        // random traffic, invariant and starvation checks only
        for (int n = 0; n < 10000; n++)
            drive_only(8'($urandom_range(0, 255)));
        drive_only(8'h00);

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clock);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses never checked, required 0", exp_q.size());
        end
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
